// File: rtl/joy_lock_pkg.sv
// ============================================================================
// Module : joy_lock_pkg
// Brief  : Shared FSM state encoding and joystick quadrant types.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package joy_lock_pkg;

  typedef enum logic [2:0] {
    S_ENTRY = 3'd0,
    S_PASS  = 3'd1,
    S_FAIL  = 3'd2,
    S_LOCK  = 3'd3
  } state_t;

  typedef logic [1:0] quad_t;

  // Encoded as {y_high, x_high}
  localparam quad_t QUAD_LL = 2'b00;
  localparam quad_t QUAD_LR = 2'b01;
  localparam quad_t QUAD_UL = 2'b10;
  localparam quad_t QUAD_UR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/joy_quadrant.sv
// ============================================================================
// Module : joy_quadrant
// Brief  : Registers the joystick quadrant from two ADC samples (1-cycle latency).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module joy_quadrant
  import joy_lock_pkg::*;
#(
  parameter int              ADC_W  = 12,
  parameter logic [ADC_W-1:0] THRESH = 12'h800
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ADC_W-1:0] adc_x,
  input  logic [ADC_W-1:0] adc_y,
  output quad_t            quadrant
);

  quad_t quadrant_d;
  quad_t quadrant_q;
  logic  x_hi;
  logic  y_hi;

  assign x_hi = (adc_x >= THRESH);
  assign y_hi = (adc_y >= THRESH);

  always_comb begin
    quadrant_d = QUAD_LL;
    case ({y_hi, x_hi})
      2'b00:   quadrant_d = QUAD_LL;
      2'b01:   quadrant_d = QUAD_LR;
      2'b10:   quadrant_d = QUAD_UL;
      default: quadrant_d = QUAD_UR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      quadrant_q <= QUAD_LL;
    end else begin
      quadrant_q <= quadrant_d;
    end
  end

  assign quadrant = quadrant_q;

endmodule

`default_nettype wire

// File: rtl/joy_combo_lock.sv
// ============================================================================
// Module : joy_combo_lock
// Brief  : Combination lock: each key must arrive with the joystick held in
//          the quadrant named by the digit's low two bits.
//          Optional lockout after repeated failures: define JOY_LOCKOUT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module joy_combo_lock
  import joy_lock_pkg::*;
#(
  parameter int               CODE_LEN    = 4,
  parameter int               DIGIT_W     = 3,
  parameter int               ADC_W       = 12,
  parameter logic [ADC_W-1:0] THRESH      = 12'h800,
  parameter int               TIMEOUT_CYC = 50_000_000,
  parameter int               MAX_FAILS   = 3,
  parameter int               LOCK_CYC    = 250_000_000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [ADC_W-1:0]            adc_x,
  input  logic [ADC_W-1:0]            adc_y,
  input  logic [CODE_LEN*DIGIT_W-1:0] code,
  input  logic                        key_valid,
  input  logic [DIGIT_W-1:0]          key_code,
  output logic [1:0]                  quadrant,
  output logic                        q_match,
  output logic [$clog2(CODE_LEN+1)-1:0] digit_idx,
  output logic                        pass_flag,
  output logic                        fail_flag,
  output logic                        lockout,
  output logic [2:0]                  state
);

  localparam int IDX_W = $clog2(CODE_LEN + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  state_t             state_q,     state_d;
  logic [IDX_W-1:0]   digit_idx_q, digit_idx_d;
  logic [TMR_W-1:0]   key_tmr_q,   key_tmr_d;
  quad_t              quad_w;
  logic [DIGIT_W-1:0] cur_digit;
  logic               key_ok;
  logic               lock_trip;
  logic               lock_done;

  joy_quadrant #(
    .ADC_W  (ADC_W),
    .THRESH (THRESH)
  ) u_quadrant (
    .clk      (clk),
    .reset_n  (reset_n),
    .adc_x    (adc_x),
    .adc_y    (adc_y),
    .quadrant (quad_w)
  );

  // digit_idx reaches CODE_LEN only during S_PASS; no digit is selected then.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digit_idx_q == IDX_W'(i)) begin
        cur_digit = code[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign q_match = (quad_w == quad_t'(cur_digit[1:0]));
  assign key_ok  = (key_code == cur_digit) && q_match;

  always_comb begin
    state_d     = state_q;
    digit_idx_d = digit_idx_q;
    key_tmr_d   = key_tmr_q;
    case (state_q)
      S_ENTRY: begin
        if (!enable) begin
          digit_idx_d = '0;
          key_tmr_d   = '0;
        end else if (key_valid) begin
          key_tmr_d = '0;
          if (key_ok) begin
            digit_idx_d = digit_idx_q + IDX_W'(1);
            if (digit_idx_q == IDX_W'(CODE_LEN - 1)) begin
              state_d = S_PASS;
            end
          end else begin
            state_d     = S_FAIL;
            digit_idx_d = '0;
          end
        end else if (digit_idx_q != '0) begin
          // Silent abandon of a partial entry; not counted as a failure.
          if (key_tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            digit_idx_d = '0;
            key_tmr_d   = '0;
          end else begin
            key_tmr_d = key_tmr_q + TMR_W'(1);
          end
        end
      end
      S_PASS: begin
        state_d     = S_ENTRY;
        digit_idx_d = '0;
      end
      S_FAIL: begin
        state_d = (enable && lock_trip) ? S_LOCK : S_ENTRY;
      end
      S_LOCK: begin
        if (lock_done) begin
          state_d = S_ENTRY;
        end
      end
      default: begin
        state_d     = S_ENTRY;
        digit_idx_d = '0;
        key_tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_ENTRY;
      digit_idx_q <= '0;
      key_tmr_q   <= '0;
    end else begin
      state_q     <= state_d;
      digit_idx_q <= digit_idx_d;
      key_tmr_q   <= key_tmr_d;
    end
  end

`ifdef JOY_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LOCK_W = $clog2(LOCK_CYC + 1);

  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

  assign lock_trip = (fail_cnt_q >= FAIL_W'(MAX_FAILS - 1));
  assign lock_done = (lock_cnt_q == LOCK_W'(LOCK_CYC - 1));

  // A failure is recorded even if enable drops in S_FAIL, so it still counts.
  always_comb begin
    fail_cnt_d = fail_cnt_q;
    lock_cnt_d = '0;
    case (state_q)
      S_PASS: fail_cnt_d = '0;
      S_FAIL: begin
        if (fail_cnt_q < FAIL_W'(MAX_FAILS)) begin
          fail_cnt_d = fail_cnt_q + FAIL_W'(1);
        end
      end
      S_LOCK: begin
        if (lock_done) begin
          fail_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      default: fail_cnt_d = fail_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fail_cnt_q <= '0;
      lock_cnt_q <= '0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign lockout = (state_q == S_LOCK);
`else
  logic unused_cfg;

  assign lock_trip  = 1'b0;
  assign lock_done  = 1'b1;
  assign lockout    = 1'b0;
  assign unused_cfg = ^{MAX_FAILS[0], LOCK_CYC[0]};
`endif

  assign quadrant  = quad_w;
  assign digit_idx = digit_idx_q;
  assign pass_flag = (state_q == S_PASS);
  assign fail_flag = (state_q == S_FAIL);
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_joy_combo_lock.sv
// ============================================================================
// Module : tb_joy_combo_lock
// Brief  : Directed vector table plus hand sequences for timeout, lockout,
//          reset and enable corner cases.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_joy_combo_lock;

  localparam int CODE_LEN = 4;
  localparam int DIGIT_W  = 3;
  localparam int ADC_W    = 12;
`ifdef JOY_LOCKOUT_EN
  localparam int EXP_LOCK_CYC = 20;
  localparam logic [2:0] EXP_LOCK_ST = 3'd3;
  localparam logic EXP_LOCKOUT = 1'b1;
`else
  localparam int EXP_LOCK_CYC = 0;
  localparam logic [2:0] EXP_LOCK_ST = 3'd0;
  localparam logic EXP_LOCKOUT = 1'b0;
`endif

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic                        enable;
  logic [ADC_W-1:0]            adc_x;
  logic [ADC_W-1:0]            adc_y;
  logic [CODE_LEN*DIGIT_W-1:0] code;
  logic                        key_valid;
  logic [DIGIT_W-1:0]          key_code;
  logic [1:0]                  quadrant;
  logic                        q_match;
  logic [2:0]                  digit_idx;
  logic                        pass_flag;
  logic                        fail_flag;
  logic                        lockout;
  logic [2:0]                  state;

  int total = 0;
  int bad   = 0;

  joy_combo_lock #(
    .CODE_LEN    (CODE_LEN),
    .DIGIT_W     (DIGIT_W),
    .ADC_W       (ADC_W),
    .THRESH      (12'h800),
    .TIMEOUT_CYC (10),
    .MAX_FAILS   (3),
    .LOCK_CYC    (20)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .adc_x     (adc_x),
    .adc_y     (adc_y),
    .code      (code),
    .key_valid (key_valid),
    .key_code  (key_code),
    .quadrant  (quadrant),
    .q_match   (q_match),
    .digit_idx (digit_idx),
    .pass_flag (pass_flag),
    .fail_flag (fail_flag),
    .lockout   (lockout),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        kv;
    logic [2:0]  key;
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  e_st;
    logic [2:0]  e_idx;
    logic [1:0]  e_quad;
    logic        e_qm;
    logic        chk_qm;
    logic        e_pass;
    logic        e_fail;
    logic        e_lock;
  } vec_t;

  vec_t tbl[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic press(input logic [2:0] k, input logic [11:0] x, input logic [11:0] y);
    enable    = 1'b1;
    adc_x     = x;
    adc_y     = y;
    key_valid = 1'b0;
    tick();
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter_code(input string tag);
    press(3'd1, 12'hA00, 12'h100);
    chk({tag, "_idx1"}, digit_idx, 3'd1);
    press(3'd7, 12'hA00, 12'hA00);
    press(3'd2, 12'h100, 12'hA00);
    press(3'd5, 12'hA00, 12'h100);
    chk({tag, "_pass"}, pass_flag, 1'b1);
    chk({tag, "_pass_st"}, state, 3'd1);
    tick();
    chk({tag, "_pass_end"}, pass_flag, 1'b0);
    chk({tag, "_idx0"}, digit_idx, 3'd0);
  endtask

  task automatic wrong_key();
    key_valid = 1'b1;
    key_code  = 3'd0;
    tick();
    chk("wrong_fail_flag", fail_flag, 1'b1);
    key_valid = 1'b0;
    tick();
  endtask

  initial begin
    int lcnt;
    int fails_seen;

    code      = {3'd5, 3'd2, 3'd7, 3'd1};
    reset_n   = 1'b0;
    enable    = 1'b1;
    adc_x     = 12'hA00;
    adc_y     = 12'hA00;
    key_valid = 1'b0;
    key_code  = 3'd0;

    //            en  kv   key   x        y        st    idx   quad  qm    cqm   pass  fail  lock
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 12'hA00, 12'h100, 3'd0, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 3'd1, 12'hA00, 12'hA00, 3'd0, 3'd1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 3'd7, 12'h100, 12'hA00, 3'd0, 3'd2, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 3'd2, 12'hA00, 12'h100, 3'd0, 3'd3, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 3'd5, 12'hA00, 12'h100, 3'd1, 3'd4, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 3'd0, 12'h100, 12'h100, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 3'd1, 12'h100, 12'h100, 3'd2, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 3'd0, 12'hA00, 12'h100, 3'd0, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 3'd3, 12'hA00, 12'h100, 3'd2, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 3'd1, 12'hA00, 12'h100, 3'd0, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 3'd1, 12'hA00, 12'h100, 3'd0, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 3'd0, 12'hA00, 12'h100, 3'd0, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state, with ADC inputs high so a stuck quadrant is visible.
    tick();
    tick();
    chk("rst_state", state, 3'd0);
    chk("rst_idx", digit_idx, 3'd0);
    chk("rst_quad", quadrant, 2'd0);
    chk("rst_pass", pass_flag, 1'b0);
    chk("rst_fail", fail_flag, 1'b0);
    chk("rst_lock", lockout, 1'b0);
    reset_n = 1'b1;

    // Correct entry, wrong quadrant, wrong key, keys in S_FAIL and disabled.
    for (int i = 0; i < 12; i++) begin
      enable    = tbl[i].en;
      key_valid = tbl[i].kv;
      key_code  = tbl[i].key;
      adc_x     = tbl[i].x;
      adc_y     = tbl[i].y;
      tick();
      chk($sformatf("vec%0d_state", i), state, tbl[i].e_st);
      chk($sformatf("vec%0d_idx", i), digit_idx, tbl[i].e_idx);
      chk($sformatf("vec%0d_quad", i), quadrant, tbl[i].e_quad);
      if (tbl[i].chk_qm) chk($sformatf("vec%0d_qmatch", i), q_match, tbl[i].e_qm);
      chk($sformatf("vec%0d_pass", i), pass_flag, tbl[i].e_pass);
      chk($sformatf("vec%0d_fail", i), fail_flag, tbl[i].e_fail);
      chk($sformatf("vec%0d_lock", i), lockout, tbl[i].e_lock);
    end
    key_valid = 1'b0;

    // Third failure: lockout for LOCK_CYC cycles with keys hammered throughout.
    key_valid = 1'b1;
    key_code  = 3'd0;
    tick();
    chk("lk_fail_flag", fail_flag, 1'b1);
    lcnt = 0;
    for (int i = 0; i < 40; i++) begin
      key_valid = 1'b1;
      key_code  = 3'd1;
      tick();
      if (!lockout) break;
      lcnt++;
      chk("lk_key_ignored", digit_idx, 3'd0);
    end
    key_valid = 1'b0;
    chk("lk_cycles", lcnt, EXP_LOCK_CYC);
    chk("lk_exit_state", state, 3'd0);
    chk("lk_exit_idx", digit_idx, 3'd0);
    wrong_key();
    chk("lk_cnt_cleared", state, 3'd0);
    chk("lk_cnt_cleared_lock", lockout, 1'b0);
    enter_code("post_lock");

    // Inter-key timeout: expiry on the TIMEOUT_CYC-th idle cycle.
    press(3'd1, 12'hA00, 12'h100);
    press(3'd7, 12'hA00, 12'hA00);
    adc_x = 12'h100;
    adc_y = 12'hA00;
    fails_seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (fail_flag) fails_seen++;
    end
    chk("to_before_expiry", digit_idx, 3'd2);
    tick();
    if (fail_flag) fails_seen++;
    chk("to_expired_idx", digit_idx, 3'd0);
    chk("to_no_fail", fails_seen, 0);
    chk("to_state", state, 3'd0);

    // Key on the expiry cycle is evaluated and advances.
    press(3'd1, 12'hA00, 12'h100);
    press(3'd7, 12'hA00, 12'hA00);
    adc_x = 12'h100;
    adc_y = 12'hA00;
    for (int i = 0; i < 9; i++) tick();
    key_valid = 1'b1;
    key_code  = 3'd2;
    tick();
    key_valid = 1'b0;
    chk("to_key_wins", digit_idx, 3'd3);
    press(3'd5, 12'hA00, 12'h100);
    chk("to_key_wins_pass", pass_flag, 1'b1);
    tick();

    // Reset in the middle of a lockout.
    wrong_key();
    wrong_key();
    wrong_key();
    chk("rl_locked_state", state, EXP_LOCK_ST);
    for (int i = 0; i < 5; i++) tick();
    chk("rl_still_locked", lockout, EXP_LOCKOUT);
    adc_x   = 12'hA00;
    adc_y   = 12'hA00;
    reset_n = 1'b0;
    tick();
    chk("rl_state", state, 3'd0);
    chk("rl_lock", lockout, 1'b0);
    chk("rl_idx", digit_idx, 3'd0);
    chk("rl_quad", quadrant, 2'd0);
    chk("rl_pass", pass_flag, 1'b0);
    chk("rl_fail", fail_flag, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("rl_after_lock", lockout, 1'b0);
    wrong_key();
    chk("rl_cnt_cleared", state, 3'd0);

    // Enable dropped mid-entry.
    press(3'd1, 12'hA00, 12'h100);
    press(3'd7, 12'hA00, 12'hA00);
    chk("en_mid_idx", digit_idx, 3'd2);
    enable = 1'b0;
    tick();
    chk("en_off_idx", digit_idx, 3'd0);
    chk("en_off_state", state, 3'd0);
    chk("en_off_fail", fail_flag, 1'b0);
    chk("en_off_pass", pass_flag, 1'b0);
    enable = 1'b1;
    enter_code("post_enable");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/joy_combo_lock.md
JOY_COMBO_LOCK -- requirements
Module: joy_combo_lock

Interface
REQ-001 SHALL declare parameter CODE_LEN, default 4, number of digits in the code (2..16).
REQ-002 SHALL declare parameter DIGIT_W, default 3, bits per code digit.
REQ-003 SHALL declare parameter ADC_W, default 12, joystick ADC sample width.
REQ-004 SHALL declare parameter THRESH, default 12'h800, per-axis quadrant split point.
REQ-005 SHALL declare parameter TIMEOUT_CYC, default 50_000_000, idle cycles allowed between keys.
REQ-006 SHALL declare parameter MAX_FAILS, default 3, wrong entries before lockout.
REQ-007 SHALL declare parameter LOCK_CYC, default 250_000_000, lockout duration in cycles.
REQ-008 Ports: clk in 1 system clock; reset_n in 1 reset, synchronous, active-low.
REQ-009 Ports: enable in 1 lock armed; adc_x, adc_y in ADC_W joystick samples.
REQ-010 Ports: code in CODE_LEN*DIGIT_W packed secret, digit 0 in LSBs; key_valid in 1 single-cycle key strobe; key_code in DIGIT_W key value.
REQ-011 Ports: quadrant out 2 registered joystick quadrant; q_match out 1 quadrant equals target; digit_idx out $clog2(CODE_LEN+1) digits accepted.
REQ-012 Ports: pass_flag out 1 one-cycle success pulse; fail_flag out 1 one-cycle wrong-entry pulse; lockout out 1 lock active; state out 3 FSM state.

Function
REQ-013 quadrant SHALL register {adc_y>=THRESH, adc_x>=THRESH} each cycle, giving 1-cycle latency.
REQ-014 Target quadrant of digit i SHALL be code[i][1:0]; q_match = (quadrant == target of digit_idx).
REQ-015 FSM states SHALL be S_ENTRY, S_PASS, S_FAIL, S_LOCK.
REQ-016 In S_ENTRY, key_valid with key_code==code[digit_idx] and q_match SHALL increment digit_idx; if this was the last digit, go to S_PASS.
REQ-017 In S_ENTRY, key_valid with wrong key or q_match=0 SHALL go to S_FAIL and clear digit_idx.
REQ-018 S_PASS SHALL last 1 cycle, assert pass_flag, clear fail count and digit_idx, then return to S_ENTRY.
REQ-019 S_FAIL SHALL last 1 cycle, assert fail_flag, increment fail count, then go to S_LOCK if the count reaches MAX_FAILS, else to S_ENTRY.
REQ-020 S_LOCK SHALL assert lockout, count LOCK_CYC cycles, then clear fail count and return to S_ENTRY.
REQ-021 Inter-key timer SHALL run in S_ENTRY while digit_idx>0 and restart on each key_valid.
REQ-022 At TIMEOUT_CYC, the timer SHALL clear digit_idx without a fail and without a fail_flag.
REQ-023 key_valid in the same cycle as timer expiry SHALL be evaluated and take priority over the timeout.
REQ-024 key_valid in S_PASS, S_FAIL or S_LOCK SHALL be ignored.
REQ-025 enable=0 SHALL force S_ENTRY and clear digit_idx and the timer; S_LOCK SHALL persist until its count expires; fail count SHALL be retained.
REQ-026 Fail count SHALL saturate at MAX_FAILS; timers SHALL be sized by $clog2 and never wrap.

Reset
REQ-027 On reset_n=0 at posedge clk: state=S_ENTRY, digit_idx=0, quadrant=0, fail count=0, timers=0, pass_flag=fail_flag=lockout=0.
REQ-028 Reset mid-lockout or mid-entry SHALL abort immediately with no pulse output.

Configuration
REQ-029 Macro JOY_LOCKOUT_EN defined: REQ-019/020 lockout behaviour as specified.
REQ-030 JOY_LOCKOUT_EN undefined: S_FAIL always returns to S_ENTRY; no fail counter or lock timer is built; lockout tied 0.

Structure
REQ-031 Package joy_lock_pkg SHALL hold the state enum, quadrant typedef and quadrant encodings.
REQ-032 Sub-module joy_quadrant SHALL implement REQ-013 and be parameterised by ADC_W and THRESH.

Verification
REQ-033 Bench settings: CODE_LEN=4, code digits {1,7,2,5}, THRESH=0x800.
REQ-034 Correct entry: keys 1,7,2,5 with matching quadrants (1:x=0xA00,y=0x100; 7:x=0xA00,y=0xA00; 2:x=0x100,y=0xA00; 5:x=0xA00,y=0x100) -> one pass_flag cycle, digit_idx=0.
REQ-035 Key 1 with x=0x100,y=0x100 -> fail_flag pulse, digit_idx=0, no pass.
REQ-036 Three wrong keys with MAX_FAILS=3, LOCK_CYC=20 -> lockout high 20 cycles, keys ignored, then entry accepted.
REQ-037 Two correct keys, then idle TIMEOUT_CYC=10 -> digit_idx returns to 0, no fail_flag; key on the expiry cycle advances instead.
REQ-038 Reset asserted during lockout, and enable deasserted mid-entry -> state S_ENTRY, outputs per REQ-027/025.
